// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between N requesters and the weighted round-robin arbiter.
// The lock signal exists only when WRR_ARB_LOCK_EN is defined.
interface wrr_arbiter_if #(
    parameter int N        = 16,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]          req;
    logic [N*WEIGHT_W-1:0] weight;
    logic                  ack;
`ifdef WRR_ARB_LOCK_EN
    logic                  lock;
`endif
    logic [N-1:0]          grant;
    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_last;

    modport master (
        output req, weight, ack,
`ifdef WRR_ARB_LOCK_EN
        output lock,
`endif
        input  grant, grant_valid, grant_idx, grant_last
    );

    modport slave (
        input  req, weight, ack,
`ifdef WRR_ARB_LOCK_EN
        input  lock,
`endif
        output grant, grant_valid, grant_idx, grant_last
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter; optional WRR_ARB_LOCK_EN adds a lock input for atomic bursts.
// Latency: request to grant one cycle, all outputs registered; back-to-back grants without a bubble.
// Backpressure: a grant is held until ack; each ack spends one credit of the holder's weight.
module wrr_arbiter #(
    parameter int N        = 16,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    wrr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n, cur, cur_n;
    logic [WEIGHT_W-1:0] credit, credit_n;
    logic [N-1:0]        masked;
    logic                eff_lock, burst_end;

    // First requester at or after p, wrapping modulo N (N need not be a power of two).
    function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] jj;
        logic             hit;
        int               j;
        res = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            if (j >= N) j = j - N;
            jj = IDX_W'(j);
            if (!hit && r[jj]) begin
                hit = 1'b1;
                res = jj;
            end
        end
        return res;
    endfunction

    function automatic logic [WEIGHT_W-1:0] wt(input logic [IDX_W-1:0] idx);
        logic [WEIGHT_W-1:0] w;
        w = bus.weight[int'(idx)*WEIGHT_W +: WEIGHT_W];
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N-1)) ? '0 : i + IDX_W'(1);
    endfunction

`ifdef WRR_ARB_LOCK_EN
    assign eff_lock = bus.lock;
`else
    assign eff_lock = 1'b0;
`endif

    assign masked    = bus.req & ~(N'(1) << cur);
    assign burst_end = !bus.req[cur] || (bus.ack && credit == WEIGHT_W'(1) && !eff_lock);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cur_n    = cur;
        credit_n = credit;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    state_n  = GRANT;
                    cur_n    = sel(bus.req, ptr);
                    credit_n = wt(cur_n);
                end
            end
            GRANT: begin
                if (burst_end) begin
                    ptr_n = inc(cur);
                    if (masked != '0) begin
                        cur_n    = sel(masked, inc(cur));
                        credit_n = wt(cur_n);
                    end else begin
                        state_n  = IDLE;
                        credit_n = '0;
                    end
                end else if (bus.ack && !eff_lock) begin
                    credit_n = credit - WEIGHT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are flopped from next-state so they line up with the state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            cur             <= '0;
            credit          <= '0;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_idx   <= '0;
            bus.grant_last  <= 1'b0;
        end else begin
            state           <= state_n;
            ptr             <= ptr_n;
            cur             <= cur_n;
            credit          <= credit_n;
            bus.grant       <= (state_n == GRANT) ? (N'(1) << cur_n) : '0;
            bus.grant_valid <= (state_n == GRANT);
            bus.grant_idx   <= (state_n == GRANT) ? cur_n : '0;
            bus.grant_last  <= (state_n == GRANT) && (credit_n == WEIGHT_W'(1));
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Randomized scoreboard bench for wrr_arbiter with N=5 (non-power-of-two wrap).
module tb_wrr_arbiter;
    localparam int N     = 5;
    localparam int WW    = 4;
    localparam int IDX_W = 3;

    typedef struct {
        logic             v;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic [N-1:0]     g;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lock_v = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    // Reference model state: busy flag, holder, beats left, search start.
    int m_busy = 0, m_who = 0, m_left = 0, m_ptr = 0;

    wrr_arbiter_if #(.N(N), .WEIGHT_W(WW), .IDX_W(IDX_W)) bus ();

    wrr_arbiter #(.N(N), .WEIGHT_W(WW), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic bit_of(input logic [N-1:0] r, input int i);
        logic [IDX_W-1:0] ii;
        ii = IDX_W'(i);
        return r[ii];
    endfunction

    function automatic int m_search(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (bit_of(r, (p + k) % N)) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int m_wt(input logic [N*WW-1:0] w, input int i);
        int x;
        x = int'(w[i*WW +: WW]);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e.v    = (m_busy != 0);
        e.idx  = (m_busy != 0) ? IDX_W'(m_who) : '0;
        e.last = (m_busy != 0) && (m_left == 1);
        e.g    = (m_busy != 0) ? (N'(1) << m_who) : '0;
        return e;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N*WW-1:0] w,
                                       input logic a, input logic l);
        logic [N-1:0] others;
        logic [IDX_W-1:0] ii;
        if (m_busy == 0) begin
            if (r != '0) begin
                m_who  = m_search(r, m_ptr);
                m_left = m_wt(w, m_who);
                m_busy = 1;
            end
        end else if (!bit_of(r, m_who) || (a && m_left == 1 && !l)) begin
            m_ptr     = (m_who + 1) % N;
            others    = r;
            ii        = IDX_W'(m_who);
            others[ii] = 1'b0;
            if (others != '0) begin
                m_who  = m_search(others, m_ptr);
                m_left = m_wt(w, m_who);
            end else begin
                m_busy = 0;
                m_left = 0;
            end
        end else if (a && !l) begin
            m_left = m_left - 1;
        end
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [N*WW-1:0] w, input logic a, input logic l);
        @(negedge clk);
        reset      = 1'b0;
        bus.req    = r;
        bus.weight = w;
        bus.ack    = a;
        lock_v     = l;
`ifdef WRR_ARB_LOCK_EN
        bus.lock   = l;
`endif
        model_step(r, w, a, (lock_v === 1'b1));
        sb.push_back(m_out());
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.grant !== '0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== '0 || bus.grant_last !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: async reset got grant=%b valid=%b idx=%0d last=%b, want all zero",
                     name, bus.grant, bus.grant_valid, bus.grant_idx, bus.grant_last);
        end
        m_busy = 0; m_who = 0; m_left = 0; m_ptr = 0;
        sb.push_back(m_out());
    endtask

    // Monitor: compare every registered output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.grant_valid !== e.v || bus.grant_idx !== e.idx ||
                    bus.grant_last !== e.last || bus.grant !== e.g) begin
                    miscompares++;
                    $display("FAIL grant @%0t: got valid=%b idx=%0d last=%b grant=%b, want valid=%b idx=%0d last=%b grant=%b",
                             $time, bus.grant_valid, bus.grant_idx, bus.grant_last, bus.grant,
                             e.v, e.idx, e.last, e.g);
                end
            end
        end
    end

    initial begin
        logic [N-1:0]    r;
        logic [N*WW-1:0] w;
        logic            a, l;
        bus.req = '0; bus.weight = '0; bus.ack = 1'b0;
`ifdef WRR_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        // Reset state with all requesting, then equal weights, ack always.
        do_reset("reset_state");
        for (int i = 0; i < 12; i++) drive('1, {N{4'd1}}, 1'b1, 1'b0);
        do_reset("reset_between");
        for (int i = 0; i < 24; i++) drive('1, {4'd0, 4'd3, 4'd1, 4'd2, 4'd1}, 1'b1, 1'b0);
        // Withdrawal of a stalled grant hands over to the waiting requester.
        drive(5'b00100, {4'd1, 4'd1, 4'd3, 4'd1, 4'd1}, 1'b0, 1'b0);
        drive(5'b00101, {4'd1, 4'd1, 4'd3, 4'd1, 4'd1}, 1'b0, 1'b0);
        drive(5'b00001, {4'd1, 4'd1, 4'd3, 4'd1, 4'd1}, 1'b0, 1'b0);
        drive(5'b00001, {4'd1, 4'd1, 4'd3, 4'd1, 4'd1}, 1'b1, 1'b0);
        // Wrap from N-1 to 0, zero weight behaves as one.
        for (int i = 0; i < 10; i++) drive(5'b10001, {4'd0, 4'd1, 4'd1, 4'd1, 4'd1}, 1'b1, 1'b0);
        // Reset mid-burst on idx3, then restart from index 0.
        drive(5'b01000, {4'd1, 4'd3, 4'd1, 4'd1, 4'd1}, 1'b0, 1'b0);
        drive(5'b01000, {4'd1, 4'd3, 4'd1, 4'd1, 4'd1}, 1'b1, 1'b0);
        drive(5'b01000, {4'd1, 4'd3, 4'd1, 4'd1, 4'd1}, 1'b0, 1'b0);
        do_reset("reset_mid_burst");
        for (int i = 0; i < 6; i++) drive(5'b01010, {N{4'd2}}, 1'b1, 1'b0);
`ifdef WRR_ARB_LOCK_EN
        do_reset("reset_lock");
        for (int i = 0; i < 2; i++) drive(5'b00110, {N{4'd1}}, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(5'b00110, {N{4'd1}}, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(5'b00110, {N{4'd1}}, 1'b1, 1'b0);
`endif
        // Randomized traffic: requests, weights and acks change independently.
        r = '0;
        w = {N{4'd1}};
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 49) == 0) w = (N*WW)'({$urandom, $urandom});
            a = ($urandom_range(0, 3) != 0);
`ifdef WRR_ARB_LOCK_EN
            l = ($urandom_range(0, 5) == 0);
`else
            l = 1'b0;
`endif
            drive(r, w, a, l);
            if (i == 1000) do_reset("reset_random");
        end
        for (int i = 0; i < 3; i++) drive('0, w, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Registered, weighted round-robin arbiter for N requesters sharing one downstream resource (memory port, writeback bus, dispatch slot). It generalises the team's single-cycle round-robin arbiter: grants are held across a ready/ack handshake, each requester receives up to a programmable number of consecutive accepted beats before the pointer rotates, and back-to-back grants between requesters issue without a bubble.

## Interface
- `N`, 16: number of requesters, ≥1; need not be a power of two.
- `WEIGHT_W`, 4: width of each per-requester weight field.
- `IDX_W`, `$clog2(N)` (minimum 1): derived; width of `grant_idx` and of the pointer.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input N: request per requester; level, may drop at any time.
- `weight` input N*WEIGHT_W: weight of requester i at bits [i*WEIGHT_W +: WEIGHT_W]; sampled at grant load; value 0 treated as 1.
- `ack` input 1: downstream accepts the current beat; meaningful only while `grant_valid`=1.
- `grant` output N: one-hot grant, all zero when idle.
- `grant_valid` output 1: `grant` is non-zero.
- `grant_idx` output IDX_W: binary index of the granted requester; 0 when idle.
- `grant_last` output 1: high when the current beat is the last credit of the burst (credit==1).
- `lock` input 1: present only with `WRR_ARB_LOCK_EN`; see Configuration.

## Operation
- State: `ptr` (IDX_W), `cur` (IDX_W), `credit` (WEIGHT_W), FSM {IDLE, GRANT}.
- Reset values: IDLE, `ptr`=0, `cur`=0, `credit`=0, `grant`=0, `grant_valid`=0, `grant_idx`=0, `grant_last`=0.
- Selection function `sel(p)`: the first i with `req[i]`=1, searching p, p+1, …, N-1, 0, …, p-1 (modulo N, with correct wrap for non-power-of-two N).
- IDLE: if `req`≠0, go to GRANT with `cur`=sel(`ptr`) and `credit`=max(weight[cur],1). Otherwise stay.
- GRANT: `grant`=1<<`cur` is held stable. The burst **ends** in any of these cases:
  - `ack` and `credit`==1.
  - `ack` and `req[cur]`=0.
  - no `ack` and `req[cur]`=0 (withdrawal).
- On a burst end: `ptr` becomes `cur`+1 (wrapping to 0 after N-1). If any requester is still asking, evaluated as `req` with bit `cur` cleared, then `cur` becomes sel(`cur`+1) over that masked vector, `credit` is reloaded, and the FSM stays in GRANT. This is a back-to-back grant with no idle cycle. Otherwise the FSM goes to IDLE.
- Otherwise, `ack` decrements `credit` and the grant is held. Without `ack`, all state holds.
- The pointer rotates only at a burst end. A requester cannot be granted twice in a row while another requester is asking.
- `credit` arithmetic is unsigned and never underflows; it is 0 only in IDLE.

## Timing
- All outputs are registered. `req` rising in cycle t gives `grant_valid` at t+1 at the earliest.
- A burst end at edge t presents the next grant at t+1. A new requester waits at most (N-1)·(2^WEIGHT_W−1) accepted beats plus N withdrawal cycles.
- `ack` while `grant_valid`=0 is ignored.
- `grant_last` is valid in the same cycle as `grant`.
- Asynchronous `reset` mid-burst forces every output to 0 immediately. The first grant after release starts the search from index 0.

## Configuration
- `WRR_ARB_LOCK_EN` defined:
  - Adds the `lock` input.
  - While `lock`=1 in GRANT, `ack` does not decrement `credit` and a `credit`==1 ack does not end the burst. This supports atomic multi-beat transfers.
  - Withdrawal (`req[cur]`=0) still ends the burst.
  - `lock` is ignored in IDLE.
- `WRR_ARB_LOCK_EN` undefined: no `lock` port; behaviour is identical to `lock`=0.

## Test plan
- Reset with `req`=4'b1111 held during and after reset; N=4, all weights=1, `ack` constant 1. Required: grant_idx sequence 0,1,2,3,0,… with one grant per cycle and no idle cycles.
- N=4, weights {1,2,1,3} (idx0..3), `req`=4'b1111, `ack`=1. Required repeating grant_idx pattern 0,1,1,2,3,3,3, with `grant_last`=1 on idx0, on the second idx1 beat, on idx2, and on the third idx3 beat.
- Grant on idx2 (weight 3) with `ack`=0, then `req[2]` dropped while `req`[0]=1. Required: the next cycle grants idx0; `ptr` moves past 2; no ack is consumed.
- Non-power-of-two N=5, `req`=5'b10001, weights=1, `ack`=1. Required: alternation 4,0,4,0, confirming wrap from 4 to 0; `weight`=0 on idx4 behaves as 1.
- Assert `reset` mid-burst on idx3 (credit 2). Required: `grant`=0 and `grant_valid`=0 in the same cycle without waiting for a clock edge; after release with `req`=4'b1010, the first grant is idx1.
- With `WRR_ARB_LOCK_EN`: idx1 has weight 1 and `lock`=1, and 4 acks are given. Required: idx1 holds for all 4 beats; after `lock` drops, the next ack ends the burst and idx2 is granted.
